// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier operand sequencer.
// Holds the FSM state encoding and the counter-width helper.
package booth_pkg;

  localparam int DEFAULT_WIDTH       = 32;
  localparam int DEFAULT_MUL_LATENCY = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  // A latency of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/booth_mul_sequencer_if.sv
// Signal bundle around booth_mul_sequencer: operand input, multiplier side, product output.
// slave is the sequencer's view; master is the surrounding producer/multiplier/consumer view.
interface booth_mul_sequencer_if
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   in_a;
  logic signed [WIDTH-1:0]   in_b;
  logic                      mul_en;
  logic signed [WIDTH-1:0]   mul_a;
  logic signed [WIDTH-1:0]   mul_b;
  logic signed [2*WIDTH-1:0] mul_result;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [2*WIDTH-1:0] out_prod;
  logic                      busy;

  modport slave (
    input  in_valid, in_a, in_b, mul_result, out_ready,
    output in_ready, mul_en, mul_a, mul_b, out_valid, out_prod, busy
  );

  modport master (
    output in_valid, in_a, in_b, mul_result, out_ready,
    input  in_ready, mul_en, mul_a, mul_b, out_valid, out_prod, busy
  );

endinterface

// File: rtl/mul_operand_fifo.sv
// Synchronous operand FIFO; read data is the head entry, valid whenever empty_o is low.
// No fall-through: a push becomes visible to the reader one edge later.
module mul_operand_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_dat_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/booth_mul_sequencer.sv
// Issues buffered operand pairs to a multi-cycle multiplier and captures each product.
// Latency MUL_LATENCY+1 from accept to out_valid; a held product stalls issue, in_ready is !full.
module booth_mul_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
  input logic                 clk,
  input logic                 reset,
  booth_mul_sequencer_if.slave bus
);

  localparam int              CNT_W    = cnt_width(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

  seq_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic signed [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic signed [2*WIDTH-1:0] out_prod_q, out_prod_d;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic [2*WIDTH-1:0]        fifo_wdat;
  logic [2*WIDTH-1:0]        fifo_rdat;

  assign push      = bus.in_valid && !fifo_full;
  assign fifo_wdat = {bus.in_a, bus.in_b};

  mul_operand_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (fifo_wdat),
    .pop_i      (pop),
    .pop_dat_o  (fifo_rdat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    out_prod_d = out_prod_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          out_prod_d = bus.mul_result;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Handing off the product and loading the next pair share one edge.
        if (bus.out_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      cnt_d   = '0;
      mul_a_d = fifo_rdat[2*WIDTH-1:WIDTH];
      mul_b_d = fifo_rdat[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      out_prod_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      out_prod_q <= out_prod_d;
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.mul_en    = (state_q == RUN);
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_prod  = out_prod_q;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty;

endmodule
